// File: rtl/fir_i2s_tx.sv
// fir_i2s_tx: requantizes filtered samples to 16 bits, buffers them and
// serializes each one as a mono sample on both channels of a Philips I2S link.
module fir_i2s_tx #(
   parameter int SHIFT      = 9,
   parameter int BCLK_DIV   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          in_valid,
   input  logic [31:0]                   in_data,
   input  logic                          clr_flags,
   output logic                          bclk,
   output logic                          lrck,
   output logic                          sdata,
   output logic                          ovf,
   output logic                          udf,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int DW = $clog2(BCLK_DIV);
   localparam logic signed [32:0] HALF = 33'sd1 <<< (SHIFT - 1);

   logic signed [32:0] ext;
   logic signed [32:0] rnd;
   logic signed [32:0] shr;
   logic [15:0]        sat;

   logic          rq_valid_q, rq_valid_d;
   logic [15:0]   rq_data_q, rq_data_d;
   logic [DW-1:0] div_q, div_d;
   logic          bclk_q, bclk_d;
   logic          lrck_q, lrck_d;
   logic          sdata_q, sdata_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [31:0]   w_q, w_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic [LW-1:0] wr_q, wr_d;
   logic [LW-1:0] rd_q, rd_d;
   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [15:0]   mem_d [FIFO_DEPTH];

   logic fall;
   logic pop;
   logic push;
   logic full;
   logic empty;
   logic [15:0] rd_word;

   // Round half up in 33 bits so the offset can never wrap the sign.
   always_comb begin
      ext = signed'({in_data[31], in_data});
      rnd = ext + HALF;
      shr = rnd >>> SHIFT;
      if (shr > 33'sd32767) begin
         sat = 16'h7fff;
      end else if (shr < -33'sd32768) begin
         sat = 16'h8000;
      end else begin
         sat = shr[15:0];
      end
   end

   assign fifo_level = wr_q - rd_q;
   assign full       = (fifo_level == LW'(FIFO_DEPTH));
   assign empty      = (fifo_level == '0);
   assign rd_word    = mem_q[rd_q[AW-1:0]];

   always_comb begin
      rq_valid_d = in_valid;
      rq_data_d  = sat;

      div_d  = div_q + DW'(1);
      bclk_d = bclk_q;
      fall   = 1'b0;
      if (div_q == DW'(BCLK_DIV - 1)) begin
         div_d  = '0;
         bclk_d = ~bclk_q;
         fall   = bclk_q;
      end

      cnt_d   = cnt_q;
      lrck_d  = lrck_q;
      sdata_d = sdata_q;
      w_d     = w_q;
      pop     = 1'b0;
      ovf_d   = ovf_q & ~clr_flags;
      udf_d   = udf_q & ~clr_flags;

      // Bit for slot c is W[32-c]; slot 0 carries the outgoing LSB.
      if (fall) begin
         cnt_d   = cnt_q + 5'd1;
         lrck_d  = cnt_d[4];
         sdata_d = w_q[5'd0 - cnt_d];
         if (cnt_d == 5'd0) begin
            if (empty) begin
               w_d   = '0;
               udf_d = 1'b1;
            end else begin
               pop = 1'b1;
               w_d = {rd_word, rd_word};
            end
         end
      end

      push = rq_valid_q & (~full | pop);
      if (rq_valid_q & ~push) begin
         ovf_d = 1'b1;
      end

      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push) begin
         mem_d[wr_q[AW-1:0]] = rq_data_q;
         wr_d = wr_q + LW'(1);
      end
      if (pop) begin
         rd_d = rd_q + LW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rq_valid_q <= 1'b0;
         rq_data_q  <= '0;
         div_q      <= '0;
         bclk_q     <= 1'b0;
         lrck_q     <= 1'b1;
         sdata_q    <= 1'b0;
         cnt_q      <= 5'd31;
         w_q        <= '0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         wr_q       <= '0;
         rd_q       <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rq_valid_q <= rq_valid_d;
         rq_data_q  <= rq_data_d;
         div_q      <= div_d;
         bclk_q     <= bclk_d;
         lrck_q     <= lrck_d;
         sdata_q    <= sdata_d;
         cnt_q      <= cnt_d;
         w_q        <= w_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         mem_q      <= mem_d;
      end
   end

   assign bclk  = bclk_q;
   assign lrck  = lrck_q;
   assign sdata = sdata_q;
   assign ovf   = ovf_q;
   assign udf   = udf_q;

endmodule

// File: tb/tb_fir_i2s_tx.sv
// tb_fir_i2s_tx: directed stimulus with a sample scoreboard checked against
// an I2S receiver model that decodes both channels from the serial stream.
module tb_fir_i2s_tx;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        clr_flags = 1'b0;
   logic        bclk, lrck, sdata, ovf, udf;
   logic [2:0]  fifo_level;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_q [$];
   int          frame_cnt = 0;
   int          frames = 0;
   int          slot = 99;
   logic [15:0] cur_exp = '0;
   logic [15:0] prev_exp = '0;
   logic [15:0] lsh = '0;
   logic [15:0] rsh = '0;
   time         last_t = 0;

   logic [31:0] tin  [8] = '{32'hFF000200, 32'h00000100, 32'h000000FF,
                             32'hFFFFFFFF, 32'hFFFFFEFF, 32'h7FFFFFFF,
                             32'h80000000, 32'h00FFFE00};
   logic [15:0] tout [8] = '{16'h8001, 16'h0001, 16'h0000, 16'h0000,
                             16'hFFFF, 16'h7FFF, 16'h8000, 16'h7FFF};

   always #5 clk = ~clk;

   fir_i2s_tx #(
      .SHIFT(9),
      .BCLK_DIV(4),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .in_valid(in_valid),
      .in_data(in_data),
      .clr_flags(clr_flags),
      .bclk(bclk),
      .lrck(lrck),
      .sdata(sdata),
      .ovf(ovf),
      .udf(udf),
      .fifo_level(fifo_level)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Frame start: the model FIFO pops exactly when the DUT does.
   always @(negedge lrck) begin
      if (rstn === 1'b1) begin
         if (frames > 0) begin
            chk("frame_period", 32'($time - last_t), 32'd2560);
         end
         last_t = $time;
         frames++;
         frame_cnt++;
         prev_exp = cur_exp;
         cur_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
         slot = 0;
      end
   end

   always @(posedge bclk) begin
      if (rstn === 1'b1 && slot < 32) begin
         chk($sformatf("lrck_slot%0d", slot), 32'(lrck),
             (slot >= 16) ? 32'd1 : 32'd0);
         if (slot == 0) begin
            if (frames >= 2) begin
               chk("right_word", {16'h0, rsh[14:0], sdata}, {16'h0, prev_exp});
            end
         end else if (slot <= 16) begin
            lsh = {lsh[14:0], sdata};
            if (slot == 16) begin
               chk("left_word", {16'h0, lsh}, {16'h0, cur_exp});
            end
         end else begin
            rsh = {rsh[14:0], sdata};
         end
         slot++;
      end
   end

   always @(negedge rstn) begin
      exp_q.delete();
      frames = 0;
      slot = 99;
   end

   task automatic wait_frame();
      int start = frame_cnt;
      int n = 0;
      while (frame_cnt == start && n < 600) begin
         @(posedge clk);
         n++;
      end
      chk("frame_timeout", 32'(n < 600), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] d, input logic [15:0] s);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (exp_q.size() < 4) exp_q.push_back(s);
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_bclk"}, 32'(bclk), 32'd0);
      chk({pfx, "_lrck"}, 32'(lrck), 32'd1);
      chk({pfx, "_sdata"}, 32'(sdata), 32'd0);
      chk({pfx, "_ovf"}, 32'(ovf), 32'd0);
      chk({pfx, "_udf"}, 32'(udf), 32'd0);
      chk({pfx, "_level"}, 32'(fifo_level), 32'd0);
   endtask

   task automatic pulse_clr();
      clr_flags = 1'b1;
      @(posedge clk);
      #1;
      clr_flags = 1'b0;
   endtask

   initial begin
      #2 rstn = 1'b0;
      #1;
      chk_reset_vals("rst");
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;

      // Underflow: empty FIFO gives silent frames and sets udf.
      wait_frame();
      wait_frame();
      chk("udf_set", 32'(udf), 32'd1);
      chk("ovf_idle", 32'(ovf), 32'd0);
      pulse_clr();
      chk("udf_clr", 32'(udf), 32'd0);

      // Rounding, saturation and serial format.
      for (int i = 0; i < 8; i++) begin
         wait_frame();
         repeat (2) @(posedge clk);
         #1;
         drive(tin[i], tout[i]);
         chk("lat_pre", 32'(fifo_level), 32'd0);
         @(posedge clk);
         #1;
         chk("lat_post", 32'(fifo_level), 32'd1);
      end
      wait_frame();
      pulse_clr();
      chk("udf_clr2", 32'(udf), 32'd0);
      wait_frame();
      chk("udf_after_last", 32'(udf), 32'd1);

      // Overflow: five writes within one frame, fifth dropped.
      wait_frame();
      repeat (2) @(posedge clk);
      #1;
      for (int k = 1; k <= 5; k++) begin
         drive(32'(k) << 9, 16'(k));
      end
      @(posedge clk);
      #1;
      chk("ovf_level", 32'(fifo_level), 32'd4);
      chk("ovf_set", 32'(ovf), 32'd1);
      drive(32'd6 << 9, 16'd6);
      clr_flags = 1'b1;
      @(posedge clk);
      #1;
      clr_flags = 1'b0;
      chk("ovf_clr_prec", 32'(ovf), 32'd1);
      pulse_clr();
      chk("ovf_clr", 32'(ovf), 32'd0);
      chk("ovf_level2", 32'(fifo_level), 32'd4);
      repeat (5) wait_frame();

      // Reset in the middle of left-channel bit 8.
      wait_frame();
      repeat (2) @(posedge clk);
      #1;
      drive(32'hFFFFFEFF, 16'hFFFF);
      drive(32'h00000200, 16'h0001);
      @(posedge clk);
      #1;
      chk("mid_level2", 32'(fifo_level), 32'd2);
      wait_frame();
      repeat (64) @(posedge clk);
      #1;
      chk("mid_sdata", 32'(sdata), 32'd1);
      chk("mid_lrck", 32'(lrck), 32'd0);
      chk("mid_level1", 32'(fifo_level), 32'd1);
      chk("mid_udf", 32'(udf), 32'd1);
      rstn = 1'b0;
      #1;
      chk_reset_vals("midrst");
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (3) wait_frame();
      chk("post_rst_udf", 32'(udf), 32'd1);
      chk("post_rst_level", 32'(fifo_level), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
